// File: rtl/aes_lab_pkg.sv
// Shared definitions for the AES-128 lab: widths, pipeline latency,
// the FIPS-197 test vector and the readback FSM state encoding.
package aes_lab_pkg;

    localparam int AES_W        = 128;
    localparam int BYTE_W       = 8;
    localparam int AES_PIPE_LAT = 21;

    // FIPS-197 appendix C.1 vector used by the lab top
    localparam logic [AES_W-1:0] TV_PLAINTEXT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [AES_W-1:0] TV_KEY        = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [AES_W-1:0] TV_CIPHERTEXT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_READ   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_SEND   = 3'd4,
        ST_DONE   = 3'd5
    } rb_state_t;

endpackage

// File: rtl/word_serializer.sv
// Streams a 128-bit word out MSB byte first over a valid/ready interface.
// The word itself is held by the parent; this unit only owns the byte index
// and the valid flag, so the output byte cannot change while stalled.
module word_serializer
    import aes_lab_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [AES_W-1:0]  i_word,
    input  logic              i_ready,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_last
);

    logic [3:0] r_idx;
    logic       r_valid;
    logic       w_fire;

    assign w_fire  = r_valid && i_ready;
    assign o_last  = w_fire && (r_idx == 4'd0);
    assign o_valid = r_valid;
    assign o_data  = r_valid ? i_word[{r_idx, 3'b000} +: BYTE_W] : '0;

    // Load starts at byte 15; each handshake steps down until byte 0 is taken
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx   <= 4'd0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_idx   <= 4'd15;
            r_valid <= 1'b1;
        end else if (w_fire) begin
            if (r_idx == 4'd0) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx - 4'd1;
            end
        end
    end

endmodule

// File: rtl/aes_ct_readback.sv
// Ciphertext RAM reader: waits for the AES pipeline to settle, reads one word,
// compares it with the golden value and streams it out byte by byte.
module aes_ct_readback
    import aes_lab_pkg::*;
#(
    parameter int ADDR_W        = 1,
    parameter int RD_ADDR       = 0,
    parameter int SETTLE_CYCLES = AES_PIPE_LAT,
    parameter int RD_LAT        = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [AES_W-1:0]  i_expected,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_rden,
    input  logic [AES_W-1:0]  i_ram_q,
    output logic [BYTE_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    output logic [AES_W-1:0]  o_captured,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_match
);

    localparam int               SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       LAT_LAST    = 2'(RD_LAT - 1);

    rb_state_t        r_state;
    rb_state_t        w_next;
    logic [SET_W-1:0] r_settle_cnt;
    logic [1:0]       r_lat_cnt;
    logic [AES_W-1:0] r_expected;
    logic [AES_W-1:0] r_captured;
    logic             r_done;
    logic             r_match;
    logic             w_load;
    logic             w_last;

    // Capture happens on the edge ending the RD_LAT-th cycle after READ
    assign w_load = (r_state == ST_WAIT) && (r_lat_cnt == LAT_LAST);

    assign o_ram_addr = ADDR_W'(RD_ADDR);
    assign o_ram_rden = (r_state == ST_READ);
    assign o_busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_done     = r_done;
    assign o_match    = r_match;
    assign o_captured = r_captured;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start is only honoured from IDLE or DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (i_start) w_next = ST_SETTLE;
            ST_SETTLE:        if (r_settle_cnt == SETTLE_LAST) w_next = ST_READ;
            ST_READ:          w_next = ST_WAIT;
            ST_WAIT:          if (w_load) w_next = ST_SEND;
            ST_SEND:          if (w_last) w_next = ST_DONE;
            default:          w_next = ST_IDLE;
        endcase
    end

    // Counters, golden value, captured word and the done/match result
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_settle_cnt <= '0;
            r_lat_cnt    <= '0;
            r_expected   <= '0;
            r_captured   <= '0;
            r_done       <= 1'b0;
            r_match      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_expected   <= i_expected;
                        r_settle_cnt <= '0;
                        r_done       <= 1'b0;
                        r_match      <= 1'b0;
                    end
                end
                ST_SETTLE: r_settle_cnt <= r_settle_cnt + 1'b1;
                ST_READ:   r_lat_cnt <= '0;
                ST_WAIT: begin
                    r_lat_cnt <= r_lat_cnt + 1'b1;
                    if (w_load) begin
                        r_captured <= i_ram_q;
                    end
                end
                ST_SEND: begin
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_match <= (r_captured == r_expected);
                    end
                end
                default: ;
            endcase
        end
    end

    word_serializer u_ser (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_word  (r_captured),
        .i_ready (i_tx_ready),
        .o_data  (o_tx_data),
        .o_valid (o_tx_valid),
        .o_last  (w_last)
    );

endmodule

// File: tb/tb_aes_ct_readback.sv
// Bench for aes_ct_readback: three instances (default timing and two short
// settle/latency variants) fed by a latency-accurate RAM model; bytes,
// latency and compare result are predicted from the stored word directly.
module tb_aes_ct_readback;

    localparam int LAT   [3] = '{2, 1, 4};
    localparam int SET   [3] = '{21, 3, 3};
    localparam int RADDR [3] = '{0, 1, 0};
    localparam logic [127:0] BASIC = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] JUNK  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic         clk = 1'b0;
    logic         rst;
    logic         start     [3];
    logic [127:0] expected  [3];
    logic [0:0]   ramAddr   [3];
    logic         ramRden   [3];
    logic [127:0] ramQ      [3];
    logic [7:0]   txData    [3];
    logic         txValid   [3];
    logic         txReady   [3];
    logic [127:0] captured  [3];
    logic         busy      [3];
    logic         done      [3];
    logic         match     [3];

    logic [127:0] mem [3][2];
    logic         pv  [3][1:4];
    logic [127:0] pd  [3][1:4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_ct_readback #(.ADDR_W(1), .RD_ADDR(RADDR[0]), .SETTLE_CYCLES(SET[0]), .RD_LAT(LAT[0])) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_expected(expected[0]),
        .o_ram_addr(ramAddr[0]), .o_ram_rden(ramRden[0]), .i_ram_q(ramQ[0]),
        .o_tx_data(txData[0]), .o_tx_valid(txValid[0]), .i_tx_ready(txReady[0]),
        .o_captured(captured[0]), .o_busy(busy[0]), .o_done(done[0]), .o_match(match[0]));

    aes_ct_readback #(.ADDR_W(1), .RD_ADDR(RADDR[1]), .SETTLE_CYCLES(SET[1]), .RD_LAT(LAT[1])) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_expected(expected[1]),
        .o_ram_addr(ramAddr[1]), .o_ram_rden(ramRden[1]), .i_ram_q(ramQ[1]),
        .o_tx_data(txData[1]), .o_tx_valid(txValid[1]), .i_tx_ready(txReady[1]),
        .o_captured(captured[1]), .o_busy(busy[1]), .o_done(done[1]), .o_match(match[1]));

    aes_ct_readback #(.ADDR_W(1), .RD_ADDR(RADDR[2]), .SETTLE_CYCLES(SET[2]), .RD_LAT(LAT[2])) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_expected(expected[2]),
        .o_ram_addr(ramAddr[2]), .o_ram_rden(ramRden[2]), .i_ram_q(ramQ[2]),
        .o_tx_data(txData[2]), .o_tx_valid(txValid[2]), .i_tx_ready(txReady[2]),
        .o_captured(captured[2]), .o_busy(busy[2]), .o_done(done[2]), .o_match(match[2]));

    // RAM read pipeline: data appears exactly LAT cycles after a read request
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                for (int k = 1; k <= 4; k++) begin
                    pv[i][k] <= 1'b0;
                    pd[i][k] <= '0;
                end
            end else begin
                for (int k = 4; k > 1; k--) begin
                    pv[i][k] <= pv[i][k-1];
                    pd[i][k] <= pd[i][k-1];
                end
                pv[i][1] <= ramRden[i];
                pd[i][1] <= mem[i][ramAddr[i]];
            end
        end
    end

    // Outside the valid read slot the RAM output is junk
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ramQ[i] = pv[i][LAT[i]] ? pd[i][LAT[i]] : JUNK;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One readback on instance i; optional start injections and mid-SEND reset
    task automatic applyStimulus(input int i, input logic [127:0] expVal, input bit randReady,
                                 input int settleInject, input int sendInject, input int abortAt);
        logic [127:0] word = mem[i][RADDR[i]];
        logic [127:0] altExp = ~expVal;
        logic [7:0]   held = '0;
        bit           stalled = 0;
        int           lat = 0;
        int           acc = 0;
        int           cyc = 0;
        @(negedge clk);
        start[i] = 1'b1;
        expected[i] = expVal;
        txReady[i] = 1'b0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start[i] = 1'b0;
            if (lat == settleInject) begin
                start[i] = 1'b1;
                expected[i] = altExp;
            end
        end while (!txValid[i] && lat < 200);
        start[i] = 1'b0;
        checkOutput($sformatf("latency%0d", i), 128'(lat), 128'(1 + SET[i] + 1 + LAT[i]));
        if (!txValid[i]) return;
        while (acc < 16 && cyc < 2000) begin
            if (acc == abortAt) begin
                rst = 1'b1;
                #1;
                checkOutput("rstTxValid", 128'(txValid[i]), 128'd0);
                checkOutput("rstBusy", 128'(busy[i]), 128'd0);
                checkOutput("rstCaptured", captured[i], 128'd0);
                checkOutput("rstDone", 128'(done[i]), 128'd0);
                @(negedge clk);
                rst = 1'b0;
                txReady[i] = 1'b0;
                return;
            end
            checkOutput($sformatf("txValidHeld%0d", acc), 128'(txValid[i]), 128'd1);
            if (!txValid[i]) break;
            if (stalled) checkOutput("stallStable", 128'(txData[i]), 128'(held));
            txReady[i] = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            start[i] = 1'b0;
            if (acc == sendInject) begin
                start[i] = 1'b1;
                expected[i] = altExp;
                if (acc == 15) txReady[i] = 1'b1;
            end
            if (txReady[i]) begin
                checkOutput($sformatf("byte%0d", 15 - acc), 128'(txData[i]), 128'(word[8*(15-acc) +: 8]));
                acc++;
                stalled = 0;
            end else begin
                stalled = 1;
                held = txData[i];
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        start[i] = 1'b0;
        txReady[i] = 1'b0;
        checkOutput("bytesAccepted", 128'(acc), 128'd16);
        checkOutput("done", 128'(done[i]), 128'd1);
        checkOutput("busyAtDone", 128'(busy[i]), 128'd0);
        checkOutput("validAtDone", 128'(txValid[i]), 128'd0);
        checkOutput("captured", captured[i], word);
        checkOutput("match", 128'(match[i]), 128'(word == expVal));
        repeat (3) @(negedge clk);
        checkOutput("doneHeld", 128'(done[i]), 128'd1);
        checkOutput("idleAfterDone", 128'(busy[i]), 128'd0);
    endtask

    initial begin
        logic [127:0] w;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            expected[i] = '0;
            txReady[i] = 1'b0;
        end
        mem[0][0] = BASIC;
        mem[0][1] = JUNK ^ 128'h1;
        mem[1][0] = ~BASIC;
        mem[1][1] = {$urandom, $urandom, $urandom, $urandom};
        mem[2][0] = {$urandom, $urandom, $urandom, $urandom};
        mem[2][1] = ~mem[2][0];
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rstValid", 128'(txValid[0]), 128'd0);
        checkOutput("rstData", 128'(txData[0]), 128'd0);
        checkOutput("rstBusy0", 128'(busy[0]), 128'd0);
        checkOutput("rstDone0", 128'(done[0]), 128'd0);
        checkOutput("rstMatch0", 128'(match[0]), 128'd0);
        checkOutput("rstCapt0", captured[0], 128'd0);
        checkOutput("rstRden0", 128'(ramRden[0]), 128'd0);
        checkOutput("rstAddr0", 128'(ramAddr[0]), 128'(RADDR[0]));
        checkOutput("rstAddr1", 128'(ramAddr[1]), 128'(RADDR[1]));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] basic readback");
        applyStimulus(0, BASIC, 0, -1, -1, -1);

        $display("[TB] mismatch in last bit");
        applyStimulus(0, 128'h0123456789abcdeffedcba9876543211, 0, -1, -1, -1);

        $display("[TB] backpressure");
        applyStimulus(0, BASIC, 1, -1, -1, -1);

        $display("[TB] start while busy in SETTLE and SEND");
        applyStimulus(0, BASIC, 1, 5, 7, -1);
        applyStimulus(0, BASIC, 1, 10, 15, -1);

        $display("[TB] reset mid-SEND then full restart");
        applyStimulus(0, BASIC, 1, -1, -1, 5);
        repeat (2) @(negedge clk);
        checkOutput("postRstValid", 128'(txValid[0]), 128'd0);
        applyStimulus(0, BASIC, 0, -1, -1, -1);

        $display("[TB] random words");
        for (int n = 0; n < 4; n++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            mem[0][0] = w;
            applyStimulus(0, (n % 2 == 0) ? w : (w ^ (128'h1 << $urandom_range(0, 127))), 1, -1, -1, -1);
        end

        $display("[TB] parameter sweep");
        applyStimulus(1, mem[1][1], 1, -1, -1, -1);
        applyStimulus(2, mem[2][0], 1, 2, 3, -1);
        mem[1][1] = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(1, ~mem[1][1], 0, -1, 15, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
